// File: rtl/qspi_cmd_framer_pkg.sv
// Shared definitions for the QSPI host-word command framer.
//  - FSM state encoding (3-bit, legacy-compatible constants)
//  - response status codes
//  - header word field offsets and controller mode values
//  - ceil_div helper for derived sizing
package qspi_host_pkg;

  // FSM states
  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIRE  = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  // Response status codes (rsp_data[15:8])
  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_LEN_OVF  = 8'h01;
  localparam logic [7:0] ST_ACK_TMO  = 8'h02;
  localparam logic [7:0] ST_BAD_MODE = 8'h03;

  // Header word field offsets
  localparam int CMD_LSB  = 0;
  localparam int LEN_LSB  = 8;
  localparam int MODE_LSB = 16;

  // Controller transfer modes; 2'd3 is not a legal mode
  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_DUAL   = 2'd1;
  localparam logic [1:0] MODE_QUAD   = 2'd2;
  localparam logic [1:0] MODE_BAD    = 2'd3;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/qspi_cmd_framer_if.sv
// Bus bundle between the host word stream / response channel, the framer,
// and the qspi_mem_controller trigger port.
//  Host stream : s_valid, s_data, s_ready
//  Response    : rsp_valid, rsp_data {status, readout}, rsp_ready
//  Controller  : mc_trigger, mc_mode, mc_cmd, mc_data, mc_busy, mc_readout
//  Status      : idle
// Modport slave is the framer side; master is the host/controller side.
interface qspi_cmd_framer_if #(
  parameter int WORD_W    = 32,
  parameter int MAX_BYTES = 259
);
  logic                   s_valid;
  logic [WORD_W-1:0]      s_data;
  logic                   s_ready;
  logic                   mc_trigger;
  logic [1:0]             mc_mode;
  logic [7:0]             mc_cmd;
  logic [MAX_BYTES*8-1:0] mc_data;
  logic                   mc_busy;
  logic [7:0]             mc_readout;
  logic                   rsp_valid;
  logic [15:0]            rsp_data;
  logic                   rsp_ready;
  logic                   idle;

  modport slave (
    input  s_valid, s_data, mc_busy, mc_readout, rsp_ready,
    output s_ready, mc_trigger, mc_mode, mc_cmd, mc_data, rsp_valid, rsp_data, idle
  );

  modport master (
    output s_valid, s_data, mc_busy, mc_readout, rsp_ready,
    input  s_ready, mc_trigger, mc_mode, mc_cmd, mc_data, rsp_valid, rsp_data, idle
  );
endinterface

// File: rtl/qspi_cmd_framer_cycle_timeout.sv
// Cycle timeout for the controller trigger acknowledge.
//  clk_in, reset : clock, asynchronous active-high reset
//  start         : holds the counter at zero
//  run           : counts one per cycle while high
//  expired       : high in the cycle whose edge completes LIMIT run cycles
module cycle_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk_in,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic expired
);
  localparam int WIDTH = $clog2(LIMIT + 1);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (run && count != LAST) begin
      count <= count + WIDTH'(1);
    end
  end

  // Count 0..LIMIT-1 spans LIMIT cycles, so the trigger is held exactly LIMIT cycles.
  assign expired = run && !start && (count == LAST);

endmodule

// File: rtl/qspi_cmd_framer.sv
// Host-word front end for qspi_mem_controller.
// Takes a header word plus len payload words over valid/ready, frames one
// memory command, fires the controller with an acknowledged, time-limited
// trigger and returns a {status, readout} response word.
//  clk_in : host clock
//  reset  : asynchronous, active-high
//  bus    : qspi_cmd_framer_if.slave (host stream, response, controller port)
module qspi_cmd_framer
  import qspi_host_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int MAX_BYTES   = 259,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                clk_in,
  input  logic                reset,
  qspi_cmd_framer_if.slave    bus
);
  localparam int DATA_W    = MAX_BYTES * 8;
  localparam int MAX_WORDS = ceil_div(DATA_W, WORD_W);
  // len is 8 bits wide; a larger buffer simply never overflows.
  localparam logic [7:0] LEN_LIMIT = (MAX_WORDS > 255) ? 8'd255 : 8'(MAX_WORDS);

  logic [2:0]        state;
  logic [7:0]        len_q;
  logic [7:0]        cmd_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        status_q;
  logic [7:0]        readout_q;

  logic [7:0] hdr_cmd;
  logic [7:0] hdr_len;
  logic [1:0] hdr_mode;
  logic       s_ready_c;
  logic       accept;
  logic       expired;

  assign hdr_cmd  = bus.s_data[CMD_LSB +: 8];
  assign hdr_len  = bus.s_data[LEN_LSB +: 8];
  assign hdr_mode = bus.s_data[MODE_LSB +: 2];

  // A rejected header with len==0 must not swallow the next host word.
  assign s_ready_c = (state == S_IDLE) || (state == S_LOAD) ||
                     (state == S_DRAIN && len_q != 8'd0);
  assign accept    = bus.s_valid && s_ready_c;

  cycle_timeout #(.LIMIT(ACK_TIMEOUT)) u_ack_timeout (
    .clk_in  (clk_in),
    .reset   (reset),
    .start   (state != S_FIRE),
    .run     (state == S_FIRE),
    .expired (expired)
  );

  // NOTE: the payload buffer is an ordinary flop vector that must read zero
  // after reset and on every new header, so it is reset like any control flop.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      len_q     <= '0;
      cmd_q     <= '0;
      mode_q    <= '0;
      data_q    <= '0;
      status_q  <= '0;
      readout_q <= '0;
    end else begin
      case (state)
        S_INIT: begin
          // A controller left running across reset is allowed to finish.
          if (!bus.mc_busy) state <= S_IDLE;
        end
        S_IDLE: begin
          if (accept) begin
            cmd_q     <= hdr_cmd;
            mode_q    <= hdr_mode;
            data_q    <= '0;
            len_q     <= hdr_len;
            readout_q <= '0;
            if (hdr_mode == MODE_BAD) begin
              status_q <= ST_BAD_MODE;
              state    <= S_DRAIN;
            end else if (hdr_len > LEN_LIMIT) begin
              status_q <= ST_LEN_OVF;
              state    <= S_DRAIN;
            end else begin
              status_q <= ST_OK;
              state    <= (hdr_len == 8'd0) ? S_FIRE : S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            data_q <= {data_q[DATA_W-WORD_W-1:0], bus.s_data};
            len_q  <= len_q - 8'd1;
            if (len_q == 8'd1) state <= S_FIRE;
          end
        end
        S_DRAIN: begin
          if (accept) begin
            len_q <= len_q - 8'd1;
            if (len_q == 8'd1) state <= S_RESP;
          end else if (len_q == 8'd0) begin
            state <= S_RESP;
          end
        end
        S_FIRE: begin
          if (bus.mc_busy) begin
            state <= S_RUN;
          end else if (expired) begin
            status_q <= ST_ACK_TMO;
            state    <= S_RESP;
          end
        end
        S_RUN: begin
          if (!bus.mc_busy) begin
            readout_q <= bus.mc_readout;
            status_q  <= ST_OK;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Handshake outputs decode straight from state, so reset clears them at once.
  assign bus.s_ready    = s_ready_c;
  assign bus.mc_trigger = (state == S_FIRE);
  assign bus.rsp_valid  = (state == S_RESP);
  assign bus.idle       = (state == S_IDLE);
  assign bus.mc_mode    = mode_q;
  assign bus.mc_cmd     = cmd_q;
  assign bus.mc_data    = data_q;
  assign bus.rsp_data   = {status_q, readout_q};

endmodule

// File: tb/tb_qspi_cmd_framer.sv
// Directed bench for qspi_cmd_framer: a 32-bit instance with an 8-cycle
// acknowledge timeout and a 64-bit instance with default timeout.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_qspi_cmd_framer;
  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_in = ~clk_in;

  qspi_cmd_framer_if #(.WORD_W(32), .MAX_BYTES(259)) b32 ();
  qspi_cmd_framer_if #(.WORD_W(64), .MAX_BYTES(259)) b64 ();

  qspi_cmd_framer #(.WORD_W(32), .MAX_BYTES(259), .ACK_TIMEOUT(8)) dut32 (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (b32)
  );

  qspi_cmd_framer #(.WORD_W(64), .MAX_BYTES(259), .ACK_TIMEOUT(255)) dut64 (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (b64)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accept edge.
  task automatic send32(input logic [31:0] w);
    int n = 0;
    b32.s_valid = 1'b1;
    b32.s_data  = w;
    while (!b32.s_ready && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 50) check("send32_ready_wait", 256'(n), 256'(0));
    @(negedge clk_in);
    b32.s_valid = 1'b0;
  endtask

  task automatic send64(input logic [63:0] w);
    int n = 0;
    b64.s_valid = 1'b1;
    b64.s_data  = w;
    while (!b64.s_ready && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 50) check("send64_ready_wait", 256'(n), 256'(0));
    @(negedge clk_in);
    b64.s_valid = 1'b0;
  endtask

  // From S_FIRE: one-cycle busy pulse, then readout presented as busy falls.
  task automatic busy_pulse32(input logic [7:0] rd);
    b32.mc_busy = 1'b1;
    @(negedge clk_in);
    b32.mc_busy    = 1'b0;
    b32.mc_readout = rd;
    @(negedge clk_in);
  endtask

  task automatic take_rsp32();
    b32.rsp_ready = 1'b1;
    @(negedge clk_in);
    b32.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic trig_seen;
    int   tcnt;

    b32.s_valid = 1'b0; b32.s_data = '0; b32.mc_busy = 1'b0;
    b32.mc_readout = '0; b32.rsp_ready = 1'b0;
    b64.s_valid = 1'b0; b64.s_data = '0; b64.mc_busy = 1'b0;
    b64.mc_readout = '0; b64.rsp_ready = 1'b0;

    // ---- reset state
    repeat (2) @(negedge clk_in);
    check("rst_s_ready",   256'(b32.s_ready),    256'(0));
    check("rst_trigger",   256'(b32.mc_trigger), 256'(0));
    check("rst_rsp_valid", 256'(b32.rsp_valid),  256'(0));
    check("rst_idle",      256'(b32.idle),       256'(0));
    check("rst_rsp_data",  256'(b32.rsp_data),   256'(0));
    check("rst_mc_data",   256'(|b32.mc_data),   256'(0));
    check("rst_mc_cmd",    256'(b32.mc_cmd),     256'(0));
    check("rst64_mc_data", 256'(|b64.mc_data),   256'(0));
    reset = 1'b0;
    @(negedge clk_in);
    check("init_to_idle",  256'(b32.idle),       256'(1));
    check("idle_s_ready",  256'(b32.s_ready),    256'(1));

    // ---- T1: len 0, trigger one cycle after header accept
    send32(32'h0000_0006);
    check("t1_trigger_latency", 256'(b32.mc_trigger), 256'(1));
    check("t1_cmd",             256'(b32.mc_cmd),     256'(8'h06));
    check("t1_s_ready_fire",    256'(b32.s_ready),    256'(0));
    busy_pulse32(8'h3C);
    check("t1_rsp_valid", 256'(b32.rsp_valid), 256'(1));
    check("t1_rsp_data",  256'(b32.rsp_data),  256'(16'h003C));
    take_rsp32();
    check("t1_rsp_drop",  256'(b32.rsp_valid), 256'(0));
    check("t1_idle",      256'(b32.idle),      256'(1));

    // ---- T2: three payload words, dual mode
    send32(32'h0001_0302);
    send32(32'h1122_3344);
    send32(32'h5566_7788);
    check("t2_no_trigger_loading", 256'(b32.mc_trigger), 256'(0));
    send32(32'h99AA_BBCC);
    check("t2_trigger",  256'(b32.mc_trigger),    256'(1));
    check("t2_data",     256'(b32.mc_data[95:0]), 256'(96'h1122_3344_5566_7788_99AA_BBCC));
    check("t2_upper0",   256'(|b32.mc_data[2071:96]), 256'(0));
    check("t2_mode",     256'(b32.mc_mode),       256'(2'd1));
    check("t2_cmd",      256'(b32.mc_cmd),        256'(8'h02));
    busy_pulse32(8'h5A);
    check("t2_rsp_data", 256'(b32.rsp_data),      256'(16'h005A));
    take_rsp32();

    // ---- T3: len 66 overflows MAX_WORDS=65 -> drained, never triggered
    trig_seen = 1'b0;
    send32(32'h0000_429F);
    for (int i = 0; i < 66; i++) begin
      send32(32'hF000_0000 + 32'(i));
      trig_seen = trig_seen | b32.mc_trigger;
    end
    check("t3_no_trigger", 256'(trig_seen),     256'(0));
    check("t3_rsp_valid",  256'(b32.rsp_valid), 256'(1));
    check("t3_rsp_data",   256'(b32.rsp_data),  256'(16'h0100));
    check("t3_data_clear", 256'(|b32.mc_data),  256'(0));
    take_rsp32();

    // Bad mode with len 66 reports BAD_MODE, not LEN_OVF
    trig_seen = 1'b0;
    send32(32'h0003_42AB);
    for (int i = 0; i < 66; i++) begin
      send32(32'hE000_0000 + 32'(i));
      trig_seen = trig_seen | b32.mc_trigger;
    end
    check("t3_mode3_no_trigger", 256'(trig_seen),     256'(0));
    check("t3_mode3_rsp",        256'(b32.rsp_data),  256'(16'h0300));
    take_rsp32();

    // Bad mode with len 0: response without consuming a word
    send32(32'h0003_0011);
    b32.s_valid = 1'b1; b32.s_data = 32'hCAFE_0000;
    check("t3_drain0_s_ready", 256'(b32.s_ready), 256'(0));
    @(negedge clk_in);
    b32.s_valid = 1'b0;
    check("t3_drain0_rsp", 256'(b32.rsp_data), 256'(16'h0300));
    take_rsp32();

    // len 65 == MAX_WORDS is accepted; the first word's top byte falls off
    send32(32'h0000_4130);
    for (int i = 0; i < 65; i++) send32(32'h0102_0300 + 32'(i));
    check("t3_len65_trigger", 256'(b32.mc_trigger),        256'(1));
    check("t3_len65_low",     256'(b32.mc_data[63:0]),     256'(64'h0102_033F_0102_0340));
    check("t3_len65_top",     256'(b32.mc_data[2071:2048]), 256'(24'h02_0300));
    busy_pulse32(8'h11);
    check("t3_len65_rsp",     256'(b32.rsp_data),          256'(16'h0011));
    take_rsp32();

    // ---- T4: no acknowledge -> trigger held 8 cycles, ACK_TMO
    send32(32'h0002_0011);
    tcnt = 0;
    while (b32.mc_trigger && tcnt < 20) begin
      tcnt++;
      @(negedge clk_in);
    end
    check("t4_trigger_cycles", 256'(tcnt),          256'(8));
    check("t4_rsp_valid",      256'(b32.rsp_valid), 256'(1));
    check("t4_rsp_data",       256'(b32.rsp_data),  256'(16'h0200));
    take_rsp32();
    check("t4_idle",           256'(b32.idle),      256'(1));

    // ---- T5: response held while rsp_ready is low
    send32(32'h0000_0005);
    busy_pulse32(8'hA5);
    b32.s_valid = 1'b1; b32.s_data = 32'h0000_0077;
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid",   256'(b32.rsp_valid), 256'(1));
      check("t5_hold_data",    256'(b32.rsp_data),  256'(16'h00A5));
      check("t5_hold_s_ready", 256'(b32.s_ready),   256'(0));
      @(negedge clk_in);
    end
    b32.s_valid = 1'b0;
    take_rsp32();
    check("t5_rsp_drop", 256'(b32.rsp_valid), 256'(0));
    // rsp_ready while no response is pending has no effect
    b32.rsp_ready = 1'b1;
    @(negedge clk_in);
    b32.rsp_ready = 1'b0;
    check("t5_spurious_ready", 256'(b32.idle), 256'(1));

    // ---- T6a: reset in S_LOAD clears outputs asynchronously
    send32(32'h0002_0321);
    send32(32'hDEAD_BEEF);
    check("t6_load_data", 256'(b32.mc_data[31:0]), 256'(32'hDEAD_BEEF));
    #2 reset = 1'b1;
    #1;
    check("t6_load_rst_s_ready", 256'(b32.s_ready),        256'(0));
    check("t6_load_rst_data",    256'(|b32.mc_data),       256'(0));
    check("t6_load_rst_mode",    256'(b32.mc_mode),        256'(0));
    check("t6_load_rst_cmd",     256'(b32.mc_cmd),         256'(0));
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    check("t6_load_recover_idle", 256'(b32.idle), 256'(1));

    // ---- T6b: reset in S_RUN; S_INIT waits for the controller to finish
    send32(32'h0000_0007);
    b32.mc_busy = 1'b1;
    @(negedge clk_in);
    check("t6_run_state", 256'(b32.mc_trigger), 256'(0));
    #2 reset = 1'b1;
    #1;
    check("t6_run_rst_idle",  256'(b32.idle),     256'(0));
    check("t6_run_rst_cmd",   256'(b32.mc_cmd),   256'(0));
    check("t6_run_rst_rsp",   256'(b32.rsp_data), 256'(0));
    @(negedge clk_in);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("t6_init_wait_idle", 256'(b32.idle),    256'(0));
      check("t6_init_s_ready",   256'(b32.s_ready), 256'(0));
    end
    b32.mc_busy = 1'b0;
    @(negedge clk_in);
    check("t6_init_done_idle", 256'(b32.idle), 256'(1));

    // ---- T6c: 64-bit words shift 64 bits per accept
    check("t6_w64_idle", 256'(b64.idle), 256'(1));
    send64(64'h0000_0000_0001_0302);
    send64(64'h1122_3344_5566_7788);
    send64(64'h99AA_BBCC_DDEE_FF00);
    send64(64'h0123_4567_89AB_CDEF);
    check("t6_w64_trigger", 256'(b64.mc_trigger), 256'(1));
    check("t6_w64_data",    256'(b64.mc_data[191:0]),
          256'(192'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00_0123_4567_89AB_CDEF));
    check("t6_w64_upper0",  256'(|b64.mc_data[2071:192]), 256'(0));
    check("t6_w64_mode",    256'(b64.mc_mode), 256'(2'd1));
    b64.mc_busy = 1'b1;
    @(negedge clk_in);
    b64.mc_busy = 1'b0; b64.mc_readout = 8'hC3;
    @(negedge clk_in);
    check("t6_w64_rsp",     256'(b64.rsp_data), 256'(16'h00C3));
    b64.rsp_ready = 1'b1;
    @(negedge clk_in);
    b64.rsp_ready = 1'b0;
    check("t6_w64_idle_end", 256'(b64.idle), 256'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
